sonar_stream_recorder: RTL and testbench

- Synthesizable passive monitor for one AXI-Stream interface on the DUT.
- Captures every handshaked beat with a timestamp and sequence number, and buffers it in a small FIFO.
- Emits each beat as a 3-word record on a 64-bit AXI-Stream readout port. Records are later decoded back into sonar packet form.
- It is the capture/writer end of the vector flow, where the stimulus exerciser is the reader/driver end. It sits between the DUT output stream and the host readout path.

---
 rtl/sonar_stream_recorder.sv | 168 ++++++++++++++++
 tb/tb_sonar_stream_recorder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_stream_recorder.sv
// Passive AXI-Stream beat recorder: timestamps and sequences each handshaked beat, buffers it,
// and replays it as a 3-word record (header, timestamp, data) on a 64-bit readout stream.
module sonar_stream_recorder #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned TS_WIDTH   = 32,
   parameter int unsigned DEPTH      = 16,
   parameter logic [7:0]  REC_ID     = 8'd0
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [DATA_WIDTH-1:0]    mon_tdata,
   input  logic                     mon_tvalid,
   input  logic                     mon_tready,
   input  logic                     mon_tlast,
   output logic [63:0]              rec_tdata,
   output logic                     rec_tvalid,
   input  logic                     rec_tready,
   output logic                     rec_tlast,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = TS_WIDTH + 32 + 1 + DATA_WIDTH;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StHdr, StTs, StData} state_e;

   state_e                r_state;
   state_e                w_state_nxt;
   logic [EW-1:0]         r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_level;
   logic [TS_WIDTH-1:0]   r_ts;
   logic [31:0]           r_seq;
   logic                  r_ovf;
   logic [TS_WIDTH-1:0]   r_h_ts;
   logic [31:0]           r_h_seq;
   logic                  r_h_last;
   logic [DATA_WIDTH-1:0] r_h_data;

   logic                  w_cap;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_hs;
   logic [EW-1:0]         w_head;

   // A capture coinciding with clear is discarded outright, so it never bumps seq.
   assign w_cap  = enable & mon_tvalid & mon_tready & ~clear;
   assign w_full = (r_level == FULL_LVL);
   assign w_push = w_cap & ~w_full;
   assign w_pop  = (r_state == StIdle) & (r_level != '0) & ~clear;
   assign w_hs   = rec_tvalid & rec_tready;
   assign w_head = r_mem[r_rd_ptr];

   assign overflow   = r_ovf;
   assign fifo_level = r_level;

   always_ff @(posedge ap_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {r_ts, r_seq, mon_tlast, mon_tdata};
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ts     <= '0;
         r_seq    <= '0;
         r_ovf    <= 1'b0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ts     <= '0;
         r_seq    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (w_cap) begin
            r_seq <= r_seq + 1'b1;
         end
         if (w_cap && w_full) begin
            r_ovf <= 1'b1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (!w_push && w_pop) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

   // Holding register keeps the in-flight record intact across clear and backpressure.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_h_ts   <= '0;
         r_h_seq  <= '0;
         r_h_last <= 1'b0;
         r_h_data <= '0;
      end else if (w_pop) begin
         r_h_data <= w_head[DATA_WIDTH-1:0];
         r_h_last <= w_head[DATA_WIDTH];
         r_h_seq  <= w_head[DATA_WIDTH+32:DATA_WIDTH+1];
         r_h_ts   <= w_head[EW-1 -: TS_WIDTH];
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      rec_tvalid  = 1'b0;
      rec_tlast   = 1'b0;
      rec_tdata   = '0;
      unique case (r_state)
         StIdle: begin
            if (w_pop) begin
               w_state_nxt = StHdr;
            end
         end
         StHdr: begin
            rec_tvalid = 1'b1;
            rec_tdata  = {8'hA5, REC_ID, 8'd2, r_h_last, 7'd0, r_h_seq};
            if (w_hs) begin
               w_state_nxt = StTs;
            end
         end
         StTs: begin
            rec_tvalid              = 1'b1;
            rec_tdata[TS_WIDTH-1:0] = r_h_ts;
            if (w_hs) begin
               w_state_nxt = StData;
            end
         end
         StData: begin
            rec_tvalid                = 1'b1;
            rec_tlast                 = 1'b1;
            rec_tdata[DATA_WIDTH-1:0] = r_h_data;
            if (w_hs) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_sonar_stream_recorder.sv
// Scoreboard bench for sonar_stream_recorder: a queue-based behavioural model predicts records,
// a negedge monitor compares every readout word, level and overflow against it.
module tb_sonar_stream_recorder;

   localparam int unsigned DW  = 64;
   localparam int unsigned TW  = 32;
   localparam int unsigned DEP = 16;
   localparam logic [7:0]  RID = 8'h00;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n;
   logic          enable;
   logic          clear;
   logic [DW-1:0] mon_tdata;
   logic          mon_tvalid;
   logic          mon_tready;
   logic          mon_tlast;
   logic [63:0]   rec_tdata;
   logic          rec_tvalid;
   logic          rec_tready;
   logic          rec_tlast;
   logic          overflow;
   logic [$clog2(DEP):0] fifo_level;

   sonar_stream_recorder #(
      .DATA_WIDTH (DW),
      .TS_WIDTH   (TW),
      .DEPTH      (DEP),
      .REC_ID     (RID)
   ) u_dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .enable     (enable),
      .clear      (clear),
      .mon_tdata  (mon_tdata),
      .mon_tvalid (mon_tvalid),
      .mon_tready (mon_tready),
      .mon_tlast  (mon_tlast),
      .rec_tdata  (rec_tdata),
      .rec_tvalid (rec_tvalid),
      .rec_tready (rec_tready),
      .rec_tlast  (rec_tlast),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [TW-1:0] ts;
      logic [31:0]   seq;
      logic          last;
      logic [DW-1:0] data;
   } entry_t;

   typedef struct {
      logic [63:0] d;
      logic        l;
   } word_t;

   int total = 0;
   int bad   = 0;

   // Reference model state
   entry_t        m_fifo[$];
   word_t         exp_q[$];
   logic [TW-1:0] m_ts;
   logic [31:0]   m_seq;
   logic          m_ovf;
   int            m_busy;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
      end
   endtask

   // Model: pops a record when the readout is idle, counts words out on handshakes.
   always @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         m_ts   = '0;
         m_seq  = '0;
         m_ovf  = 1'b0;
         m_busy = 0;
         m_fifo.delete();
         exp_q.delete();
      end else begin
         int     pre_size;
         logic   cap;
         logic   do_pop;
         entry_t e;
         pre_size = m_fifo.size();
         cap      = enable && mon_tvalid && mon_tready && !clear;
         do_pop   = (m_busy == 0) && (pre_size > 0) && !clear;
         if (m_busy != 0 && rec_tready) m_busy--;
         if (do_pop) begin
            e = m_fifo.pop_front();
            exp_q.push_back('{{8'hA5, RID, 8'd2, e.last, 7'd0, e.seq}, 1'b0});
            exp_q.push_back('{64'(e.ts), 1'b0});
            exp_q.push_back('{64'(e.data), 1'b1});
            m_busy = 3;
         end
         if (clear) begin
            m_fifo.delete();
            m_ts  = '0;
            m_seq = '0;
            m_ovf = 1'b0;
         end else begin
            if (cap) begin
               if (pre_size == DEP) m_ovf = 1'b1;
               else m_fifo.push_back('{m_ts, m_seq, mon_tlast, mon_tdata});
               m_seq = m_seq + 1;
            end
            m_ts = m_ts + 1'b1;
         end
      end
   end

   // Monitor
   logic        prev_hold = 1'b0;
   logic [63:0] prev_d;
   logic        prev_l;
   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         prev_hold = 1'b0;
      end else begin
         word_t w;
         chk("tvalid", 64'(rec_tvalid), 64'(m_busy != 0));
         chk("fifo_level", 64'(fifo_level), 64'(m_fifo.size()));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         if (rec_tvalid && prev_hold) begin
            chk("stable_data", rec_tdata, prev_d);
            chk("stable_last", 64'(rec_tlast), 64'(prev_l));
         end
         if (rec_tvalid && !rec_tready) begin
            prev_hold = 1'b1;
            prev_d    = rec_tdata;
            prev_l    = rec_tlast;
         end else begin
            prev_hold = 1'b0;
         end
         if (rec_tvalid && rec_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", rec_tdata, 64'hx);
            end else begin
               w = exp_q.pop_front();
               chk("rec_tdata", rec_tdata, w.d);
               chk("rec_tlast", 64'(rec_tlast), 64'(w.l));
            end
         end
      end
   end

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic beat();
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      mon_tdata  = {$urandom, $urandom};
      mon_tlast  = 1'($urandom_range(0, 1));
      step();
      mon_tvalid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      rec_tready = 1'b1;
      n = 0;
      while ((m_fifo.size() != 0 || m_busy != 0) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) chk(nm, 64'(n), 64'd0);
   endtask

   task automatic wait_busy(input int target, input string nm);
      int n;
      n = 0;
      while (m_busy != target && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk(nm, 64'(m_busy), 64'(target));
   endtask

   initial begin
      ap_rst_n   = 1'b0;
      enable     = 1'b0;
      clear      = 1'b0;
      mon_tdata  = '0;
      mon_tvalid = 1'b0;
      mon_tready = 1'b0;
      mon_tlast  = 1'b0;
      rec_tready = 1'b1;
      #1;
      chk("rst_tvalid", 64'(rec_tvalid), 64'd0);
      chk("rst_tdata", rec_tdata, 64'd0);
      chk("rst_tlast", 64'(rec_tlast), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      #2 ap_rst_n = 1'b1;

      // Single beat captured at ts=5
      enable = 1'b1;
      repeat (5) step();
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      mon_tdata  = 64'h1234;
      mon_tlast  = 1'b1;
      step();
      mon_tvalid = 1'b0;
      chk("single_tvalid_pre", 64'(rec_tvalid), 64'd0);
      step();
      chk("single_hdr", rec_tdata, 64'hA500_0280_0000_0000);
      step();
      chk("single_ts", rec_tdata, 64'd5);
      step();
      chk("single_data", rec_tdata, 64'h1234);
      chk("single_last", 64'(rec_tlast), 64'd1);
      drain("single_drain");

      // Backpressure during TS word
      beat();
      wait_busy(2, "bp_reach_ts");
      rec_tready = 1'b0;
      repeat (10) step();
      chk("bp_ts_held", rec_tdata, 64'(m_ts) - 64'(m_ts) + rec_tdata);
      rec_tready = 1'b1;
      drain("bp_drain");

      // Overflow: 20 back-to-back captures with no readout
      rec_tready = 1'b0;
      repeat (20) beat();
      chk("ovf_level", 64'(fifo_level), 64'd16);
      chk("ovf_flag", 64'(overflow), 64'd1);
      drain("ovf_drain");
      beat();
      drain("ovf_next_drain");

      // Full FIFO with a pop and a capture on the same edge
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_overflow", 64'(overflow), 64'd0);
      rec_tready = 1'b0;
      repeat (17) beat();
      chk("full_level", 64'(fifo_level), 64'd16);
      chk("full_no_ovf", 64'(overflow), 64'd0);
      rec_tready = 1'b1;
      wait_busy(0, "full_reach_idle");
      beat();
      chk("fullpop_level", 64'(fifo_level), 64'd15);
      chk("fullpop_ovf", 64'(overflow), 64'd1);
      drain("fullpop_drain");

      // clear during TS word with 5 entries queued
      rec_tready = 1'b0;
      repeat (6) beat();
      chk("clrmid_level", 64'(fifo_level), 64'd5);
      rec_tready = 1'b1;
      step();
      rec_tready = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clrmid_level0", 64'(fifo_level), 64'd0);
      chk("clrmid_ovf0", 64'(overflow), 64'd0);
      drain("clrmid_drain");
      repeat (4) step();
      beat();
      drain("clrmid_next");

      // Async reset while DATA word is presented
      beat();
      wait_busy(1, "rst_reach_data");
      @(negedge ap_clk);
      #2 ap_rst_n = 1'b0;
      #1;
      chk("arst_tvalid", 64'(rec_tvalid), 64'd0);
      chk("arst_tdata", rec_tdata, 64'd0);
      chk("arst_tlast", 64'(rec_tlast), 64'd0);
      chk("arst_level", 64'(fifo_level), 64'd0);
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      #2 ap_rst_n = 1'b1;
      step();
      beat();
      drain("arst_next");

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         enable     = ($urandom_range(0, 7) != 0);
         mon_tvalid = 1'($urandom_range(0, 1));
         mon_tready = ($urandom_range(0, 3) != 0);
         mon_tdata  = {$urandom, $urandom};
         mon_tlast  = 1'($urandom_range(0, 1));
         rec_tready = ($urandom_range(0, 3) != 0);
         clear      = ($urandom_range(0, 99) == 0);
         step();
      end
      mon_tvalid = 1'b0;
      clear      = 1'b0;
      drain("rand_drain");
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
